// File: rtl/sext_pipe.sv
// Immediate extractor for RV32/RV64 formats behind a two-entry skid buffer.
// Output and skid entries are fully registered; in_ready never depends on out_ready.

module sext_dec #(
  parameter int XLEN = 32
) (
  input  logic [24:0]     inst_i,
  input  logic [2:0]      op_i,
  output logic [XLEN-1:0] imm_o,
  output logic            err_o
);

  logic        s;
  logic [31:0] imm32;

  assign s = inst_i[24];

  // Every format is first built as a 32-bit value; widening to 64 then reduces to
  // replicating bit 31, which is zero for the zero-extended Z/SHAMT cases.
  always_comb begin
    imm32 = '0;
    err_o = 1'b0;
    case (op_i)
      3'b000:  imm32 = {{20{s}}, inst_i[24:13]};
      3'b001:  imm32 = {{20{s}}, inst_i[24:18], inst_i[4:0]};
      3'b010:  imm32 = {{20{s}}, inst_i[0], inst_i[23:18], inst_i[4:1], 1'b0};
      3'b011:  imm32 = {inst_i[24:5], 12'b0};
      3'b100:  imm32 = {{12{s}}, inst_i[12:5], inst_i[13], inst_i[23:14], 1'b0};
      3'b101:  imm32 = {27'b0, inst_i[12:8]};
      3'b110:  imm32 = {26'b0, (XLEN == 64) && inst_i[18], inst_i[17:13]};
      default: err_o = 1'b1;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm_o = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm_o = imm32;
  end

endmodule

module sext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      inst_i,
  input  logic [2:0]       sext_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  ent_t             new_ent;
  ent_t             out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  sext_dec #(.XLEN(XLEN)) u_dec (
    .inst_i (inst_i),
    .op_i   (sext_op),
    .imm_o  (new_ent.imm),
    .err_o  (new_ent.err)
  );
  assign new_ent.tag = in_tag;

  assign accept = in_valid && !skid_vld_q;
  assign drain  = out_vld_q && out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      // OUT frees up this edge: refill from SKID first to keep FIFO order.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = new_ent;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = new_ent;
      end
    end else if (accept) begin
      skid_d     = new_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !flush && new_ent.err && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = !skid_vld_q;
  assign out_valid = out_vld_q;
  assign imm       = out_q.imm;
  assign out_tag   = out_q.tag;
  assign out_err   = out_q.err;
  assign err_cnt   = cnt_q;

endmodule
